// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack for call/return control flow.
// Define PC_STACK_CHECK_EN for sticky overflow/underflow detection; otherwise the stack is circular.
module pc_stack_unit #(
    parameter int PC_WIDTH     = 12,
    parameter int OFFSET_WIDTH = 8,
    parameter int STACK_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_PC_src_plus1,
    input  logic                    sel_PC_src_offset,
    input  logic                    sel_PC_src_const,
    input  logic                    sel_PC_src_stack,
    input  logic                    push_stack,
    input  logic                    pop_stack,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [PC_WIDTH-1:0]     jump_addr,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int OCC_W = SP_W + 1;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]     sp;
    logic [OCC_W-1:0]    occ;

    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] stack_top;
    logic [PC_WIDTH-1:0] pc_next;
    logic [SP_W-1:0]     top_idx;
    logic                is_empty;
    logic                is_full;
    logic                push_only;
    logic                pop_only;
    logic                wr_en;
    logic                sp_inc;
    logic                occ_inc;
    logic                pop_ok;

    assign pc_plus1   = pc + PC_WIDTH'(1);
    assign offset_ext = PC_WIDTH'($signed(offset));
    assign top_idx    = sp - SP_W'(1);
    assign is_empty   = (occ == '0);
    assign is_full    = (occ == OCC_W'(STACK_DEPTH));
    // An empty stack returns to address 0 rather than stale contents.
    assign stack_top  = is_empty ? '0 : stack_mem[top_idx];

    assign push_only = push_stack & ~pop_stack;
    assign pop_only  = pop_stack & ~push_stack;
    assign pop_ok    = pop_only & ~is_empty;

`ifdef PC_STACK_CHECK_EN
    logic err_q;
    logic err_set;

    assign wr_en   = push_only & ~is_full;
    assign sp_inc  = wr_en;
    assign occ_inc = wr_en;
    assign err_set = (push_stack & pop_stack) | (push_only & is_full) | (pop_only & is_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    // A push while full overwrites the oldest slot; occupancy saturates.
    assign wr_en     = push_only;
    assign sp_inc    = push_only;
    assign occ_inc   = push_only & ~is_full;
    assign stack_err = 1'b0;
`endif

    always_comb begin
        pc_next = pc;
        if (sel_PC_src_stack) begin
            pc_next = stack_top;
        end else if (sel_PC_src_const) begin
            pc_next = jump_addr;
        end else if (sel_PC_src_offset) begin
            pc_next = pc + offset_ext;
        end else if (sel_PC_src_plus1) begin
            pc_next = pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            sp  <= '0;
            occ <= '0;
        end else begin
            pc <= pc_next;
            if (sp_inc) begin
                sp <= sp + SP_W'(1);
            end else if (pop_ok) begin
                sp <= sp - SP_W'(1);
            end
            if (occ_inc) begin
                occ <= occ + OCC_W'(1);
            end else if (pop_ok) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Entries are not reset; occupancy alone decides which ones are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_mem[sp] <= pc_plus1;
        end
    end

    assign stack_full  = is_full;
    assign stack_empty = is_empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: vector table plus call/return, overflow and reset sequences.
module tb_pc_stack_unit;

    localparam int EW = 15;
`ifdef PC_STACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sel_PC_src_plus1;
    logic        sel_PC_src_offset;
    logic        sel_PC_src_const;
    logic        sel_PC_src_stack;
    logic        push_stack;
    logic        pop_stack;
    logic [7:0]  offset;
    logic [11:0] jump_addr;
    logic [11:0] pc;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    logic [EW-1:0] exp_q[$];
    logic [11:0]   ra[$];
    int            errors;
    int            checks;

    typedef struct {
        logic        p1, of, cn, st, pu, po;
        logic [7:0]  off;
        logic [11:0] jmp;
        logic [11:0] e_pc;
        logic        e_full, e_empty;
    } vec_t;

    vec_t tbl[18];

    pc_stack_unit dut (
        .clk               (clk),
        .rst               (rst),
        .sel_PC_src_plus1  (sel_PC_src_plus1),
        .sel_PC_src_offset (sel_PC_src_offset),
        .sel_PC_src_const  (sel_PC_src_const),
        .sel_PC_src_stack  (sel_PC_src_stack),
        .push_stack        (push_stack),
        .pop_stack         (pop_stack),
        .offset            (offset),
        .jump_addr         (jump_addr),
        .pc                (pc),
        .stack_full        (stack_full),
        .stack_empty       (stack_empty),
        .stack_err         (stack_err)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        sel_PC_src_plus1  = 1'b0;
        sel_PC_src_offset = 1'b0;
        sel_PC_src_const  = 1'b0;
        sel_PC_src_stack  = 1'b0;
        push_stack        = 1'b0;
        pop_stack         = 1'b0;
        offset            = 8'h00;
        jump_addr         = 12'h000;
    endtask

    // Scoreboard compare: pops the oldest expectation and checks the live outputs
    task automatic check(input string name);
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        a = {pc, stack_full, stack_empty, stack_err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued, got pc=%h full=%b empty=%b err=%b",
                     name, a[14:3], a[2], a[1], a[0]);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, expected pc=%h full=%b empty=%b err=%b",
                         name, a[14:3], a[2], a[1], a[0], e[14:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Driver: present inputs, queue the expectation, compare after the next rising edge
    task automatic drive(input logic p1, input logic of, input logic cn, input logic st,
                         input logic pu, input logic po, input logic [7:0] off,
                         input logic [11:0] jmp, input logic [11:0] e_pc,
                         input logic e_full, input logic e_empty, input logic e_err,
                         input string name);
        sel_PC_src_plus1  = p1;
        sel_PC_src_offset = of;
        sel_PC_src_const  = cn;
        sel_PC_src_stack  = st;
        push_stack        = pu;
        pop_stack         = po;
        offset            = off;
        jump_addr         = jmp;
        exp_q.push_back({e_pc, e_full, e_empty, e_err});
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic async_reset(input string name);
        idle();
        #2;
        rst = 1'b1;
        exp_q.push_back({12'h000, 1'b0, 1'b1, 1'b0});
        #1;
        check(name);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] cur;
        logic [11:0] tgt;
        errors = 0;
        checks = 0;
        //             p1 of cn st pu po  off     jmp      e_pc     full empty
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h001, 0, 1};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h002, 0, 1};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h003, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h004, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h005, 0, 1};
        tbl[5]  = '{0, 0, 1, 0, 0, 0, 8'h00, 12'h010, 12'h010, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 8'hFC, 12'h000, 12'h00C, 0, 1};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 8'h00, 12'hFFE, 12'hFFE, 0, 1};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 8'h05, 12'h000, 12'h003, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 8'h33, 12'h777, 12'h003, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 8'h00, 12'hFFF, 12'hFFF, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 8'h00, 12'h000, 12'h000, 0, 1};
        tbl[12] = '{1, 1, 1, 0, 0, 0, 8'h7F, 12'h234, 12'h234, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 8'h10, 12'h000, 12'h244, 0, 1};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 8'h00, 12'h020, 12'h020, 0, 1};
        tbl[15] = '{0, 0, 1, 0, 1, 0, 8'h00, 12'h300, 12'h300, 0, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 1, 8'h00, 12'h000, 12'h021, 0, 1};
        tbl[17] = '{0, 1, 0, 0, 0, 0, 8'h80, 12'h000, 12'hFA1, 0, 1};

        idle();
        rst = 1'b1;
        #1;
        exp_q.push_back({12'h000, 1'b0, 1'b1, 1'b0});
        check("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].p1, tbl[i].of, tbl[i].cn, tbl[i].st, tbl[i].pu, tbl[i].po,
                  tbl[i].off, tbl[i].jmp, tbl[i].e_pc, tbl[i].e_full, tbl[i].e_empty,
                  1'b0, $sformatf("vec%0d", i));
        end

        // Reset between clock edges must clear pc without waiting for clk
        async_reset("async_rst");

        // Nested calls from distinct PCs, then one overflow push
        cur = 12'h000;
        for (int i = 0; i < 9; i++) begin
            tgt = 12'h100 + 12'(i * 16);
            ra.push_back(cur + 12'h001);
            drive(0, 0, 1, 0, 1, 0, 8'($urandom_range(0, 255)), tgt, tgt,
                  (i >= 7), 1'b0, (i == 8) ? CHK : 1'b0, $sformatf("call%0d", i));
            cur = tgt;
        end

        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1, 0, 1, 8'h00, 12'($urandom_range(0, 4095)),
                  CHK ? ra[7 - k] : ra[8 - k], 1'b0, (k == 7), CHK, $sformatf("ret%0d", k));
        end

        drive(0, 0, 0, 1, 0, 1, 8'h00, 12'h000, 12'h000, 1'b0, 1'b1, CHK, "pop_empty");
        async_reset("rst_clear");

        drive(0, 0, 1, 0, 0, 0, 8'h00, 12'h154, 12'h154, 1'b0, 1'b1, 1'b0, "pre_call");
        drive(0, 0, 1, 0, 1, 0, 8'h00, 12'h0AA, 12'h0AA, 1'b0, 1'b0, 1'b0, "call_155");
        drive(1, 1, 1, 1, 0, 0, 8'h05, 12'h0AA, 12'h155, 1'b0, 1'b0, 1'b0, "all_sel");
        drive(1, 0, 0, 0, 1, 1, 8'h00, 12'h000, 12'h156, 1'b0, 1'b0, CHK, "push_pop");
        drive(0, 0, 0, 1, 0, 1, 8'h00, 12'h000, 12'h155, 1'b0, 1'b1, CHK, "ret_after_pp");

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL leftover: %0d expectations not consumed, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PC_WIDTH, default 12, sets the program counter and return-address width.
REQ-002 Parameter OFFSET_WIDTH, default 8, sets the signed branch offset width.
REQ-003 Parameter STACK_DEPTH, default 8, sets the number of return-address entries (power of two, >=2).
REQ-004 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel_PC_src_plus1  in  1  next PC = PC+1.
- sel_PC_src_offset  in  1  conditional branch taken; next PC = PC + sign-extended offset.
- sel_PC_src_const  in  1  absolute jump; next PC = jump_addr.
- sel_PC_src_stack  in  1  return; next PC = top of stack.
- push_stack  in  1  push PC+1 (call).
- pop_stack  in  1  pop top entry (return).
- offset  in  OFFSET_WIDTH  two's-complement branch offset.
- jump_addr  in  PC_WIDTH  absolute target.
- pc  out  PC_WIDTH  current program counter, registered.
- stack_full  out  1  occupancy == STACK_DEPTH.
- stack_empty  out  1  occupancy == 0.
- stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-005 pc SHALL update only on the rising edge of clk, one cycle after the selects are presented.
REQ-006 Next-PC priority SHALL be: stack > const > offset > plus1; with no select asserted, pc SHALL hold.
REQ-007 All PC arithmetic SHALL be modulo 2^PC_WIDTH; PC+1 from all-ones wraps to 0; the offset is sign-extended before addition.
REQ-008 push_stack SHALL write (pc+1) mod 2^PC_WIDTH to entry[sp] and increment sp in the same edge as the PC update.
REQ-009 pop_stack SHALL decrement sp; sel_PC_src_stack SHALL read entry[sp-1] (pre-pop top) combinationally for that edge.
REQ-010 stack_full and stack_empty SHALL be derived from registered occupancy (width clog2(STACK_DEPTH)+1), valid the cycle after the causing edge.
REQ-011 push_stack and pop_stack together SHALL leave sp and stack contents unchanged and set stack_err; pc still follows REQ-006.
REQ-012 Push when full and pop when empty SHALL be handled per REQ-017/018.
REQ-013 sel_PC_src_stack while empty SHALL load pc with 0.
REQ-014 Stack storage SHALL be a register array; no memory macro.

Reset
REQ-015 rst high SHALL immediately force pc=0, sp=0, stack_empty=1, stack_full=0, stack_err=0, regardless of clk.
REQ-016 Stack entries need not be cleared; a reset mid-call sequence SHALL discard all pending return addresses.

Configuration
REQ-017 Macro PC_STACK_CHECK_EN defined: push when full SHALL be dropped (sp, contents unchanged) and set stack_err; pop when empty SHALL leave sp=0 and set stack_err; stack_err stays 1 until rst.
REQ-018 Macro PC_STACK_CHECK_EN undefined: stack_err SHALL be tied 0; push when full SHALL overwrite the oldest entry (circular, occupancy saturates at STACK_DEPTH); pop when empty SHALL leave sp=0; REQ-011 then leaves the stack unchanged without flagging.

Verification
REQ-019 Reset, then 5 cycles sel_PC_src_plus1 -> pc 0,1,2,3,4,5; rst asserted mid-cycle -> pc=0 without a clock edge.
REQ-020 pc=0x010, sel_PC_src_offset, offset=8'hFC -> pc=0x00C next cycle; offset=8'h05 from 0xFFE -> pc=0x003.
REQ-021 pc=0x020, sel_PC_src_const + push_stack, jump_addr=0x300 -> pc=0x300, stack_empty=0; then sel_PC_src_stack + pop_stack -> pc=0x021, stack_empty=1.
REQ-022 Nested calls: 8 pushes from distinct PCs then 8 returns -> return addresses in exact LIFO order, stack_full=1 after 8th push.
REQ-023 With PC_STACK_CHECK_EN: 9th push -> stack_err=1, 8 returns still correct; pop on empty -> pc=0, stack_err=1. Without macro: 9th push -> stack_err=0, 8 returns yield newest 8 addresses.
REQ-024 All four selects asserted with stack top=0x155, jump_addr=0x0AA -> pc=0x155; push and pop together -> sp unchanged, stack_err=1 (macro defined).
